// File: rtl/sr_icache_resp.sv
`default_nettype none
//==============================================================================
// Module   : sr_icache_resp
// Brief    : Direct-mapped instruction cache.
//            Returns hits one cycle after acceptance. Misses refill a whole
//            line from backing memory before the requested word is returned.
// Revision : 1.0
//==============================================================================
module sr_icache_resp #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inv,
    input  logic        im_req,
    input  logic [31:0] im_addr,
    output logic [31:0] im_data,
    output logic        im_drdy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    localparam int c_OB = $clog2(WORDS);
    localparam int c_IB = $clog2(LINES);
    localparam int c_TB = 30 - c_OB - c_IB;
    localparam logic [c_OB-1:0] c_LAST_BEAT = c_OB'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        REFILL  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [29:0]       r_reqAddr;
    logic [c_OB-1:0]   r_beatCnt;
    logic [LINES-1:0]  r_valid;
    logic [c_TB-1:0]   r_tagArr  [LINES];
    logic [31:0]       r_dataArr [LINES*WORDS];

    logic [c_OB-1:0]   w_off;
    logic [c_IB-1:0]   w_idx;
    logic [c_TB-1:0]   w_tag;
    logic              w_hit;
    logic [31:0]       w_readWord;
    logic              w_beatAccept;
    logic              w_lastBeat;
    logic              w_invAll;
    logic              w_capture;
    logic              w_missClr;
    logic              w_unused;

    // The request register holds a word address; byte-lane bits are dropped.
    assign w_unused     = ^im_addr[1:0];
    assign w_off        = r_reqAddr[c_OB-1:0];
    assign w_idx        = r_reqAddr[c_OB+c_IB-1:c_OB];
    assign w_tag        = r_reqAddr[29:c_OB+c_IB];
    assign w_hit        = r_valid[w_idx] && (r_tagArr[w_idx] == w_tag);
    assign w_readWord   = r_dataArr[{w_idx, w_off}];
    assign w_beatAccept = (r_state == REFILL) && mem_rvalid;
    assign w_lastBeat   = w_beatAccept && (r_beatCnt == c_LAST_BEAT);

    always_comb begin
        w_stateNext = r_state;
        im_drdy     = 1'b0;
        im_data     = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        w_invAll    = 1'b0;
        w_capture   = 1'b0;
        w_missClr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (inv) begin
                    w_invAll = 1'b1;
                end else if (im_req) begin
                    w_capture   = 1'b1;
                    w_stateNext = LOOKUP;
                end
            end
            LOOKUP: begin
                if (w_hit) begin
                    im_drdy     = 1'b1;
                    im_data     = w_readWord;
                    w_stateNext = IDLE;
                end else begin
                    w_missClr   = 1'b1;
                    w_stateNext = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_idx, {(c_OB + 2){1'b0}}};
                if (w_lastBeat) begin
                    w_stateNext = RESPOND;
                end
            end
            RESPOND: begin
                im_drdy     = 1'b1;
                im_data     = w_readWord;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_reqAddr <= '0;
            r_beatCnt <= '0;
            r_valid   <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_capture) begin
                r_reqAddr <= im_addr[31:2];
            end
            if (w_lastBeat) begin
                r_beatCnt <= '0;
            end else if (w_beatAccept) begin
                r_beatCnt <= r_beatCnt + 1'b1;
            end
            // The line stays invalid while it is being refilled, so an
            // interrupted refill never exposes a partial line.
            if (w_invAll) begin
                r_valid <= '0;
            end else if (w_missClr) begin
                r_valid[w_idx] <= 1'b0;
            end else if (w_lastBeat) begin
                r_valid[w_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_beatAccept && !rst) begin
            r_dataArr[{w_idx, r_beatCnt}] <= mem_rdata;
        end
        if (w_lastBeat && !rst) begin
            r_tagArr[w_idx] <= w_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_icache_resp.sv
`default_nettype none
//==============================================================================
// Module   : tb_sr_icache_resp
// Brief    : Scoreboard bench for sr_icache_resp, including directed cases and
//            random fetches against a line-level cache/memory model.
// Revision : 1.0
//==============================================================================
module tb_sr_icache_resp;

    localparam int LINES  = 8;
    localparam int WORDS  = 4;
    localparam int BUDGET = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        inv;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        im_drdy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    sr_icache_resp #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .inv        (inv),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_data    (im_data),
        .im_drdy    (im_drdy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] dataQ   [$];
    logic [31:0] refillQ [$];
    logic [31:0] memArr  [int unsigned];

    bit          mV [LINES];
    int unsigned mT [LINES];
    logic [31:0] mD [LINES][WORDS];

    int  beatsGiven  = 0;
    int  rspLimit    = WORDS;
    int  gapMode     = 0;
    int  lastBeatCyc = 0;
    int  rc          = 0;
    int  reqStartCyc = 0;
    int  reqLen      = 0;
    bit  prevReq     = 0;
    bit  abortFlag   = 0;
    bit  running     = 0;
    logic [31:0] curLine = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] memRead(input int unsigned wa);
        if (memArr.exists(wa)) return memArr[wa];
        return (wa * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    // Line-level model: decide hit/miss from the spec address split and
    // predict the word (and refill line) the cache must produce.
    task automatic modelIssue(input logic [31:0] a, output bit hit);
        int unsigned wa, off, idx, tg, lineWa;
        wa     = 32'(a >> 2);
        off    = wa % WORDS;
        idx    = (wa / WORDS) % LINES;
        tg     = wa / (WORDS * LINES);
        lineWa = wa - off;
        hit    = mV[idx] && (mT[idx] == tg);
        if (!hit) begin
            refillQ.push_back(lineWa * 4);
            for (int w = 0; w < WORDS; w++) mD[idx][w] = memRead(lineWa + w);
            mV[idx] = 1'b1;
            mT[idx] = tg;
        end
        dataQ.push_back(mD[idx][off]);
    endtask

    task automatic doReset();
        rst    = 1'b1;
        im_req = 1'b0;
        inv    = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        dataQ.delete();
        refillQ.delete();
        for (int i = 0; i < LINES; i++) mV[i] = 1'b0;
        rst = 1'b0;
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the
    // cycle after im_drdy.
    task automatic doFetch(input logic [31:0] a, input bit randInv);
        bit hit, got;
        int n0, dCyc;
        modelIssue(a, hit);
        im_req  = 1'b1;
        im_addr = a;
        n0      = cyc;
        got     = 1'b0;
        dCyc    = 0;
        for (int k = 0; k < BUDGET && !got; k++) begin
            @(negedge clk);
            if (im_drdy) begin
                got  = 1'b1;
                dCyc = cyc;
            end else begin
                @(posedge clk);
                #1;
                if (randInv) inv = ($urandom_range(0, 3) == 0);
            end
        end
        @(posedge clk);
        #1;
        im_req = 1'b0;
        inv    = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL fetchTimeout: got no im_drdy want one for addr %h", a);
            doReset();
        end else if (hit) begin
            chk("hitLatency", dCyc - n0, 1);
        end else begin
            chk("missStart", reqStartCyc - n0, 2);
            chk("missLatency", dCyc - lastBeatCyc, 1);
        end
    endtask

    task automatic doInvReq(input logic [31:0] a, input bit randInv);
        for (int i = 0; i < LINES; i++) mV[i] = 1'b0;
        inv     = 1'b1;
        im_req  = 1'b1;
        im_addr = a;
        @(posedge clk);
        #1;
        inv = 1'b0;
        doFetch(a, randInv);
    endtask

    task automatic doResetMid(input logic [31:0] a);
        bit hit;
        int k;
        rspLimit = 2;
        modelIssue(a, hit);
        void'(dataQ.pop_back());
        im_req  = 1'b1;
        im_addr = a;
        k = 0;
        while (beatsGiven < 2 && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        chk("midBeats", beatsGiven, 2);
        @(posedge clk);
        #1;
        im_req = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rspLimit = WORDS;
        for (int i = 0; i < LINES; i++) mV[i] = 1'b0;
        dataQ.delete();
        refillQ.delete();
        @(negedge clk);
        chk("postRstMemReq", 32'(mem_req), 0);
        chk("postRstDrdy", 32'(im_drdy), 0);
        chk("postRstMemAddr", mem_addr, 0);
        @(posedge clk);
        #1;
    endtask

    // Backing memory: answers from the DUT's refill address with the
    // configured beat spacing, and sends a stray beat after the refill.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (rst) begin
                beatsGiven = 0;
                rc         = 0;
            end else if (beatsGiven == WORDS) begin
                chk("memReqDrop", 32'(mem_req), 0);
                beatsGiven = 0;
                rc         = 0;
                if ($urandom_range(0, 1) == 1) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                end
            end else if (mem_req) begin
                bit give;
                if (gapMode == 0)      give = 1'b1;
                else if (gapMode == 1) give = ((rc % 3) == 2);
                else                   give = ($urandom_range(0, 2) != 0);
                rc++;
                if (give && beatsGiven < rspLimit) begin
                    mem_rvalid  = 1'b1;
                    mem_rdata   = memRead(32'(mem_addr >> 2) + beatsGiven);
                    beatsGiven++;
                    lastBeatCyc = cyc;
                end
            end
        end
    end

    // Monitor: pops expected words on im_drdy and expected lines on refill start.
    initial begin
        forever begin
            @(negedge clk);
            if (running && !rst) begin
                if (im_drdy) begin
                    if (dataQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpectedDrdy: got im_drdy=1 data %h want no pending fetch", im_data);
                    end else begin
                        chk("imData", im_data, dataQ.pop_front());
                    end
                end else begin
                    chk("imDataIdle", im_data, 0);
                end
                if (mem_req) begin
                    if (!prevReq) begin
                        reqStartCyc = cyc;
                        reqLen      = 0;
                        abortFlag   = 1'b0;
                        if (refillQ.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpectedRefill: got mem_addr %h want no refill", mem_addr);
                            curLine = mem_addr;
                        end else begin
                            curLine = refillQ.pop_front();
                        end
                    end
                    chk("memAddr", mem_addr, curLine);
                    reqLen++;
                end else begin
                    chk("memAddrIdle", mem_addr, 0);
                    if (prevReq && !abortFlag && gapMode == 0) chk("refillLen", reqLen, WORDS);
                end
            end else if (rst && mem_req) begin
                abortFlag = 1'b1;
            end
            prevReq = mem_req;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst     = 1'b1;
        inv     = 1'b0;
        im_req  = 1'b0;
        im_addr = '0;
        doReset();
        @(negedge clk);
        chk("rstDrdy", 32'(im_drdy), 0);
        chk("rstData", im_data, 0);
        chk("rstMemReq", 32'(mem_req), 0);
        chk("rstMemAddr", mem_addr, 0);
        running = 1'b1;
        @(posedge clk);
        #1;

        memArr[4] = 32'hA0;
        memArr[5] = 32'hA1;
        memArr[6] = 32'hA2;
        memArr[7] = 32'hA3;
        gapMode = 0;
        doFetch(32'h0000_0014, 1'b0);
        doFetch(32'h0000_001C, 1'b0);
        doFetch(32'h0000_0094, 1'b0);
        doFetch(32'h0000_0014, 1'b0);
        gapMode = 1;
        doFetch(32'h0000_0208, 1'b0);
        gapMode = 0;
        doFetch(32'h0000_0017, 1'b0);
        doInvReq(32'h0000_0014, 1'b0);
        doResetMid(32'h0000_0344);
        doFetch(32'h0000_0344, 1'b0);

        for (int n = 0; n < 300; n++) begin
            int unsigned tg, idx, off, low;
            gapMode = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0)
                memArr[$urandom_range(0, 4 * LINES * WORDS - 1)] = $urandom;
            tg  = $urandom_range(0, 3);
            idx = $urandom_range(0, LINES - 1);
            off = $urandom_range(0, WORDS - 1);
            low = $urandom_range(0, 3);
            a   = 32'(((tg * LINES + idx) * WORDS + off) * 4 + low);
            if ($urandom_range(0, 19) == 0) doInvReq(a, 1'b1);
            else                            doFetch(a, 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("dataQEmpty", dataQ.size(), 0);
        chk("refillQEmpty", refillQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_icache_resp.md
SR_ICACHE_RESP -- requirements
Module: sr_icache_resp

Interface
REQ-001 Parameter: LINES, default 8, number of direct-mapped lines (power of 2, at least 2).
REQ-002 Parameter: WORDS, default 4, number of 32-bit words per line (power of 2, at least 2).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 inv  input  1  invalidate-all request.
REQ-006 im_req  input  1  CPU fetch request; the CPU holds it with im_addr stable until im_drdy.
REQ-007 im_addr  input  32  CPU fetch byte address; bits [1:0] are ignored.
REQ-008 im_data  output  32  instruction word; valid only while im_drdy=1.
REQ-009 im_drdy  output  1  one-cycle pulse; im_data is valid in that cycle.
REQ-010 mem_req  output  1  line refill request to backing memory.
REQ-011 mem_addr  output  32  line-aligned refill byte address.
REQ-012 mem_rdata  input  32  refill data beat.
REQ-013 mem_rvalid  input  1  refill beat valid; beats arrive in order, word 0 to WORDS-1, any spacing.

Function
REQ-014 The address is split as follows: offset = addr[OB+1:2], index = addr[IB+OB+1:OB+2], tag = the remaining upper bits, where OB=log2(WORDS) and IB=log2(LINES); defaults give offset [3:2], index [6:4], tag [31:7].
REQ-015 Storage is a data array of LINES x WORDS x 32 bits, plus a tag array and one valid bit per line.
REQ-016 The FSM states are IDLE, LOOKUP, REFILL and RESPOND.
REQ-017 In IDLE, inv=1 clears all valid bits and stays in IDLE; inv has priority over im_req, and no request is captured in that cycle.
REQ-018 In IDLE, im_req=1 with inv=0 captures im_addr into a request register and moves to LOOKUP.
REQ-019 In LOOKUP, a hit (valid[index]=1 and the stored tag equals the tag) drives im_drdy=1 and im_data=data[index][offset] in the same cycle, then returns to IDLE.
- Hit latency: request at cycle N gives im_drdy at N+1.
- Hit throughput: one fetch per 2 cycles.
REQ-020 In LOOKUP, a miss moves to REFILL and clears valid[index] in the same edge.
REQ-021 In REFILL:
- mem_req=1 continuously.
- mem_addr = {tag, index, zeros}, constant for the whole refill.
- Each cycle with mem_rvalid=1 writes mem_rdata to data[index][beat count] and increments the beat count.
REQ-022 On the beat where the count equals WORDS-1:
- write that word;
- set valid[index]=1 and write tag[index];
- reset the beat count to 0;
- deassert mem_req from the next cycle;
- move to RESPOND.
REQ-023 In RESPOND, drive im_drdy=1 and im_data=data[index][offset] (the newly filled word), then return to IDLE.
- Miss latency: request at N, last beat at cycle M, im_drdy at M+1.
REQ-024 mem_rvalid outside REFILL is ignored.
REQ-025 inv outside IDLE is ignored and is not deferred.
REQ-026 im_req outside IDLE is not sampled.
REQ-027 im_drdy is 0 in IDLE and REFILL.
REQ-028 im_data is 0 whenever im_drdy=0.
REQ-029 mem_req is 0 outside REFILL.
REQ-030 mem_addr is 0 outside REFILL.
REQ-031 A refill of line X that evicts line Y does not disturb the data, tag or valid bit of any other line.
REQ-032 An address with nonzero bits [1:0] behaves identically to the same address with those bits cleared.

Reset
REQ-033 When rst=1 at a rising edge, the next state is:
- FSM in IDLE;
- all valid bits 0;
- beat count 0;
- request register 0;
- im_drdy=0, im_data=0, mem_req=0, mem_addr=0.
REQ-034 Reset applies from any state, including mid-REFILL.
- Beats already written are discarded because the line stays invalid.
- mem_req is low in the cycle after the reset edge.
REQ-035 The data and tag arrays are not required to be reset.

Verification
REQ-036 Cold miss with defaults:
- Stimulus: after reset, im_req with im_addr=0x00000014; memory returns 0xA0,0xA1,0xA2,0xA3 one beat per cycle.
- Response: mem_req high for 4 cycles with mem_addr=0x00000010; im_drdy one cycle after the last beat with im_data=0xA1.
REQ-037 Hit after fill:
- Stimulus: im_addr=0x0000001C.
- Response: im_drdy exactly 1 cycle after acceptance with im_data=0xA3; mem_req stays 0.
REQ-038 Conflict eviction:
- Stimulus: im_addr=0x00000094 (same index 1, different tag).
- Response: refill with mem_addr=0x00000090; then 0x00000014 misses again.
REQ-039 Gapped beats:
- Stimulus: mem_rvalid asserted every 3rd cycle.
- Response: correct word returned; mem_req held high throughout; exactly 4 beats consumed.
REQ-040 Invalidate:
- Stimulus: inv and im_req both high in IDLE, then im_req only.
- Response: first request not accepted; the previously-hitting address now misses and refills.
REQ-041 Reset mid-refill:
- Stimulus: rst after 2 beats.
- Response: the next cycle shows IDLE, mem_req=0, im_drdy=0; re-request of the same address performs a full 4-beat refill.
